// File: rtl/psum_requant_packer.sv
// Requantises 32-bit accumulator beats to int8 and packs them into words.
// Two-stage arithmetic pipeline, lane packer and first-word-fall-through FIFO.
module psum_requant_packer #(
  parameter int ACC_W      = 32,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int SHIFT_W    = 5,
  localparam int OUT_W     = 8 * PACK,
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [ACC_W-1:0]   in_data,
  input  logic               in_last,
  output logic               in_ready,
  input  logic [ACC_W-1:0]   cfg_bias,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_relu,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data,
  output logic [PACK-1:0]    out_keep,
  output logic               out_last,
  input  logic               out_ready,
  output logic [LVL_W-1:0]   fifo_level,
  output logic [15:0]        sat_cnt
);

  localparam int SUM_W = ACC_W + 2;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IDX_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic signed [SUM_W-1:0] MAX8 = 127;
  localparam logic signed [SUM_W-1:0] MIN8 = -128;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [PACK-1:0]  keep;
    logic             last;
  } ent_t;

  logic acc;
  logic s1_valid, s1_relu, s1_last;
  logic signed [SUM_W-1:0] s1_sum;
  logic [SHIFT_W-1:0] s1_shift;
  logic s2_valid, s2_last;
  logic [7:0] s2_byte;
  logic signed [SUM_W-1:0] rnd, shf;
  logic [7:0] q;
  logic sat;
  logic [OUT_W-1:0] pack_data, word_n;
  logic [PACK-1:0] pack_keep, keep_n;
  logic [IDX_W-1:0] pack_idx;
  logic push, pop;
  ent_t mem [FIFO_DEPTH];
  ent_t head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  // Registered level only: no combinational path from out_ready.
  assign in_ready = fifo_level <= LVL_W'(FIFO_DEPTH - 3);
  assign acc      = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_shift <= '0;
      s1_relu  <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= acc;
      if (acc) begin
        s1_sum   <= {{2{in_data[ACC_W-1]}}, in_data}
                  + {{2{cfg_bias[ACC_W-1]}}, cfg_bias};
        s1_shift <= cfg_shift;
        s1_relu  <= cfg_relu;
        s1_last  <= in_last;
      end
    end
  end

  always_comb begin
    rnd = '0;
    if (s1_shift != '0)
      rnd = SUM_W'(1) << (s1_shift - SHIFT_W'(1));
    shf = (s1_sum + rnd) >>> s1_shift;
    if (s1_relu && shf < 0)
      shf = '0;
    q   = shf[7:0];
    sat = 1'b0;
    unique case (1'b1)
      (shf > MAX8): begin q = 8'h7F; sat = 1'b1; end
      (shf < MIN8): begin q = 8'h80; sat = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_byte  <= '0;
      s2_last  <= 1'b0;
      sat_cnt  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_byte <= q;
        s2_last <= s1_last;
        if (sat && sat_cnt != 16'hFFFF)
          sat_cnt <= sat_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    word_n = pack_data;
    keep_n = pack_keep;
    word_n[8*pack_idx +: 8] = s2_byte;
    keep_n[pack_idx] = 1'b1;
    push = s2_valid &&
           (pack_idx == IDX_W'(PACK - 1) || s2_last);
  end

  assign out_valid = fifo_level != '0;
  assign pop       = out_valid & out_ready;
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head.data : '0;
  assign out_keep  = out_valid ? head.keep : '0;
  assign out_last  = out_valid & head.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_data  <= '0;
      pack_keep  <= '0;
      pack_idx   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (s2_valid) begin
        if (push) begin
          pack_data <= '0;
          pack_keep <= '0;
          pack_idx  <= '0;
        end else begin
          pack_data <= word_n;
          pack_keep <= keep_n;
          pack_idx  <= pack_idx + IDX_W'(1);
        end
      end
      if (push) begin
        mem[wr_ptr] <= '{data: word_n, keep: keep_n,
                         last: s2_last};
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1))
                ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1))
                ? '0 : rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_requant_packer.sv
// Directed bench for psum_requant_packer: arithmetic table,
// packing latency, backpressure drain and mid-stream reset.
module tb_psum_requant_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] cfg_bias = '0;
  logic [4:0]  cfg_shift = '0;
  logic        cfg_relu = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic [3:0]  fifo_level;
  logic [15:0] sat_cnt;

  int checks = 0;
  int errors = 0;
  int max_lvl = 0;

  typedef struct {
    logic [31:0] d;
    logic [31:0] b;
    logic [4:0]  sh;
    logic        relu;
    logic [7:0]  q;
    int          sat;
  } vec_t;

  vec_t vt [16];

  psum_requant_packer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu),
    .out_valid(out_valid), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last),
    .out_ready(out_ready),
    .fifo_level(fifo_level), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (int'(fifo_level) > max_lvl)
      max_lvl = int'(fifo_level);
    if (rst_n && fifo_level > 4'd8) begin
      errors++;
      $display("FAIL overflow level=%0d limit=8",
               fifo_level);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d,
                      input logic [31:0] b,
                      input logic [4:0]  sh,
                      input logic        r,
                      input logic        l);
    int w = 0;
    in_data   = d;
    cfg_bias  = b;
    cfg_shift = sh;
    cfg_relu  = r;
    in_last   = l;
    in_valid  = 1'b1;
    while (!in_ready && w < 800) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL in_ready_wait actual=0 required=1");
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out();
    int w = 0;
    while (!out_valid && w < 20) begin
      tick();
      w++;
    end
    if (!out_valid) begin
      errors++;
      $display("FAIL out_valid_wait actual=0 required=1");
    end
  endtask

  initial begin
    vt[0]  = '{32'd1000, 32'd24, 5'd4, 1'b0, 8'h40, 0};
    vt[1]  = '{32'hFFFFFFE8, 32'd0, 5'd4, 1'b0, 8'hFF, 0};
    vt[2]  = '{32'hFFFFFFE7, 32'd0, 5'd4, 1'b0, 8'hFE, 0};
    vt[3]  = '{32'h7FFFFFFF, 32'd0, 5'd0, 1'b0, 8'h7F, 1};
    vt[4]  = '{32'hFFFFFED4, 32'd0, 5'd0, 1'b0, 8'h80, 2};
    vt[5]  = '{32'hFFFFFED4, 32'd0, 5'd0, 1'b1, 8'h00, 2};
    vt[6]  = '{32'd100, 32'd27, 5'd0, 1'b0, 8'h7F, 2};
    vt[7]  = '{32'd100, 32'd28, 5'd0, 1'b0, 8'h7F, 3};
    vt[8]  = '{32'hFFFFFF9C, 32'hFFFFFFE4, 5'd0, 1'b0,
               8'h80, 3};
    vt[9]  = '{32'hFFFFFF7F, 32'd0, 5'd0, 1'b0, 8'h80, 4};
    vt[10] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 5'd31, 1'b0,
               8'h02, 4};
    vt[11] = '{32'h80000000, 32'h80000000, 5'd31, 1'b0,
               8'hFE, 4};
    vt[12] = '{32'd64, 32'd0, 5'd1, 1'b1, 8'h20, 4};
    vt[13] = '{32'hFFFFFFFD, 32'd0, 5'd1, 1'b0, 8'hFF, 4};
    vt[14] = '{32'hFFFFFFFD, 32'd0, 5'd1, 1'b1, 8'h00, 4};
    vt[15] = '{32'd1000, 32'd0, 5'd0, 1'b1, 8'h7F, 5};

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_keep", out_keep, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(vt[i].d, vt[i].b, vt[i].sh, vt[i].relu, 1'b1);
      wait_out();
      chk($sformatf("vec%0d_data", i), out_data,
          {24'h0, vt[i].q});
      chk($sformatf("vec%0d_keep", i), out_keep, 4'h1);
      chk($sformatf("vec%0d_last", i), out_last, 1);
      chk($sformatf("vec%0d_sat", i), sat_cnt, vt[i].sat);
      tick();
      chk($sformatf("vec%0d_popped", i), out_valid, 0);
    end

    out_ready = 1'b0;
    send(32'd1, 32'd0, 5'd0, 1'b0, 1'b0);
    send(32'd2, 32'd0, 5'd0, 1'b0, 1'b0);
    send(32'd3, 32'd0, 5'd0, 1'b0, 1'b0);
    send(32'd4, 32'd0, 5'd0, 1'b0, 1'b0);
    chk("lat_e0_valid", out_valid, 0);
    tick();
    chk("lat_e1_valid", out_valid, 0);
    tick();
    chk("lat_e2_valid", out_valid, 1);
    chk("pack4_data", out_data, 32'h04030201);
    chk("pack4_keep", out_keep, 4'hF);
    chk("pack4_last", out_last, 0);
    tick();
    tick();
    chk("hold_data", out_data, 32'h04030201);
    chk("hold_keep", out_keep, 4'hF);
    send(32'd5, 32'd0, 5'd0, 1'b0, 1'b0);
    send(32'd6, 32'd0, 5'd0, 1'b0, 1'b1);
    tick();
    tick();
    chk("pack_level", fifo_level, 2);
    out_ready = 1'b1;
    tick();
    chk("pack2_valid", out_valid, 1);
    chk("pack2_data", out_data, 32'h00000605);
    chk("pack2_keep", out_keep, 4'h3);
    chk("pack2_last", out_last, 1);
    tick();
    chk("pack_empty", out_valid, 0);

    out_ready = 1'b0;
    max_lvl = 0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(32'(i), 32'd0, 5'd0, 1'b0, 1'b1);
      end
      begin
        int got;
        int cyc;
        repeat (60) tick();
        chk("bp_peak", max_lvl, 8);
        chk("bp_level", fifo_level, 8);
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 40 && cyc < 800) begin
          if (out_valid) begin
            chk($sformatf("drain%0d", got),
                {out_last, out_keep, out_data},
                {1'b1, 4'h1, 32'(got)});
            got++;
          end
          tick();
          cyc++;
        end
        chk("drain_count", got, 40);
      end
    join
    tick();
    chk("drain_level", fifo_level, 0);
    chk("drain_peak", max_lvl, 8);

    out_ready = 1'b0;
    send(32'h11, 32'd0, 5'd0, 1'b0, 1'b1);
    send(32'h12, 32'd0, 5'd0, 1'b0, 1'b1);
    send(32'h13, 32'd0, 5'd0, 1'b0, 1'b1);
    send(32'h21, 32'd0, 5'd0, 1'b0, 1'b0);
    send(32'h22, 32'd0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("pre_rst_level", fifo_level, 3);
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_level", fifo_level, 0);
    chk("async_data", out_data, 0);
    chk("async_sat", sat_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", in_ready, 1);
    out_ready = 1'b1;
    send(32'h33, 32'd0, 5'd0, 1'b0, 1'b1);
    wait_out();
    chk("fresh_data", out_data, 32'h00000033);
    chk("fresh_keep", out_keep, 4'h1);
    chk("fresh_last", out_last, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
